// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
// The stage drives the request side; memory returns read data and the ack.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 16-bit MIPS core: LW/SW via a variable-latency req/ack port
// with timeout abort, upstream stall, and registered MEM/WB-facing outputs.
module mem_stage #(
    parameter logic [3:0] LW_OP   = 4'b1000,
    parameter logic [3:0] SW_OP   = 4'b1001,
    parameter logic [7:0] TIMEOUT = 8'd15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        i_inst,
    input  logic [15:0]        i_res,
    input  logic               i_wr_en,
    input  logic [2:0]         i_write_addr,
    input  logic [15:0]        i_st_data,
    mem_stage_if.master        dmem,
    output logic               o_stall,
    output logic [15:0]        o_inst_out,
    output logic [15:0]        o_wb_data,
    output logic               o_wb_en,
    output logic [2:0]         o_wb_addr,
    output logic               o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_hold_inst;
    logic [15:0] r_hold_res;
    logic [15:0] r_hold_st;
    logic [2:0]  r_hold_waddr;
    logic        r_hold_wr_en;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [15:0] r_inst_out;
    logic [15:0] r_wb_data;
    logic        r_wb_en;
    logic [2:0]  r_wb_addr;
    logic        r_err;

    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_mem_op;
    logic        w_held_sw;
    logic        w_timeout;

    assign w_is_lw   = (i_inst[15:12] == LW_OP);
    assign w_is_sw   = (i_inst[15:12] == SW_OP);
    assign w_mem_op  = w_is_lw || w_is_sw;
    assign w_held_sw = (r_hold_inst[15:12] == SW_OP);
    assign w_timeout = (r_cnt == (TIMEOUT - 8'd1));

    // Stall must drop in DONE so upstream advances past the completed op.
    assign o_stall = (r_state == S_BUSY) || ((r_state == S_IDLE) && w_mem_op);

    assign dmem.req   = r_req;
    assign dmem.we    = r_we;
    assign dmem.addr  = r_hold_res;
    assign dmem.wdata = r_hold_st;

    assign o_inst_out = r_inst_out;
    assign o_wb_data  = r_wb_data;
    assign o_wb_en    = r_wb_en;
    assign o_wb_addr  = r_wb_addr;
    assign o_err      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hold_inst  <= 16'd0;
            r_hold_res   <= 16'd0;
            r_hold_st    <= 16'd0;
            r_hold_waddr <= 3'd0;
            r_hold_wr_en <= 1'b0;
            r_cnt        <= 8'd0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_inst_out   <= 16'd0;
            r_wb_data    <= 16'd0;
            r_wb_en      <= 1'b0;
            r_wb_addr    <= 3'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_hold_inst  <= i_inst;
                        r_hold_res   <= i_res;
                        r_hold_st    <= i_st_data;
                        r_hold_waddr <= i_write_addr;
                        r_hold_wr_en <= i_wr_en;
                        r_cnt        <= 8'd0;
                        r_req        <= 1'b1;
                        r_we         <= w_is_sw;
                        r_inst_out   <= 16'd0;
                        r_wb_data    <= 16'd0;
                        r_wb_en      <= 1'b0;
                        r_wb_addr    <= 3'd0;
                        r_state      <= S_BUSY;
                    end else begin
                        r_inst_out <= i_inst;
                        r_wb_data  <= i_res;
                        r_wb_en    <= i_wr_en;
                        r_wb_addr  <= i_write_addr;
                    end
                end
                S_BUSY: begin
                    // An ack in the timeout cycle still completes normally.
                    if (dmem.ack) begin
                        r_inst_out <= r_hold_inst;
                        r_wb_addr  <= r_hold_waddr;
                        if (w_held_sw) begin
                            r_wb_data <= r_hold_res;
                            r_wb_en   <= 1'b0;
                        end else begin
                            r_wb_data <= dmem.rdata;
                            r_wb_en   <= r_hold_wr_en;
                        end
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_err      <= 1'b1;
                        r_inst_out <= 16'd0;
                        r_wb_data  <= 16'd0;
                        r_wb_en    <= 1'b0;
                        r_wb_addr  <= 3'd0;
                        r_req      <= 1'b0;
                        r_we       <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_inst_out <= 16'd0;
                    r_wb_data  <= 16'd0;
                    r_wb_en    <= 1'b0;
                    r_wb_addr  <= 3'd0;
                    r_err      <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, LW/SW with varied ack latency,
// timeout, late ack, reset mid-access and a back-to-back sequence.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [15:0] inst;
    logic [15:0] res;
    logic        wr_en;
    logic [2:0]  write_addr;
    logic [15:0] st_data;
    logic        stall;
    logic [15:0] inst_out;
    logic [15:0] wb_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic        err;

    int n_tests;
    int n_fail;
    int req_cycles;
    int req_issues;
    logic req_prev;

    mem_stage_if u_if ();

    mem_stage u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_inst       (inst),
        .i_res        (res),
        .i_wr_en      (wr_en),
        .i_write_addr (write_addr),
        .i_st_data    (st_data),
        .dmem         (u_if),
        .o_stall      (stall),
        .o_inst_out   (inst_out),
        .o_wb_data    (wb_data),
        .o_wb_en      (wb_en),
        .o_wb_addr    (wb_addr),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.req) req_cycles = req_cycles + 1;
        if (u_if.req && !req_prev) req_issues = req_issues + 1;
        req_prev = u_if.req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] i, input logic [15:0] r, input logic w,
                          input logic [2:0] a, input logic [15:0] s);
        inst       = i;
        res        = r;
        wr_en      = w;
        write_addr = a;
        st_data    = s;
    endtask

    initial begin
        int stall_cnt;
        int busy_cnt;
        n_tests    = 0;
        n_fail     = 0;
        req_cycles = 0;
        req_issues = 0;
        req_prev   = 1'b0;
        rst        = 1'b1;
        u_if.ack   = 1'b0;
        u_if.rdata = 16'd0;
        set_in(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000);

        // reset state
        cyc(); cyc();
        #1;
        chk("rst_req", u_if.req, 0);
        chk("rst_we", u_if.we, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);

        // 1: ALU pass-through
        cyc(); rst = 1'b0;
        set_in(16'h1234, 16'h00AA, 1'b1, 3'd3, 16'h0000);
        #1 chk("alu_stall", stall, 0);
        cyc(); set_in(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000);
        #1;
        chk("alu_wb_data", wb_data, 16'h00AA);
        chk("alu_wb_en", wb_en, 1);
        chk("alu_wb_addr", wb_addr, 3);
        chk("alu_inst_out", inst_out, 16'h1234);
        chk("alu_stall2", stall, 0);
        cyc(); #1 chk("nop_wb_en", wb_en, 0);

        // 2: LW, ack on third BUSY cycle
        stall_cnt = 0;
        set_in(16'h8A45, 16'h0040, 1'b1, 3'd5, 16'h0000);
        #1 if (stall) stall_cnt++;
        chk("lw_idle_req", u_if.req, 0);
        cyc(); #1 if (stall) stall_cnt++;
        chk("lw_req", u_if.req, 1);
        chk("lw_we", u_if.we, 0);
        chk("lw_addr", u_if.addr, 16'h0040);
        chk("lw_busy_wb_en", wb_en, 0);
        cyc(); #1 if (stall) stall_cnt++;
        cyc(); u_if.ack = 1'b1; u_if.rdata = 16'hBEEF;
        #1 if (stall) stall_cnt++;
        cyc(); u_if.ack = 1'b0; u_if.rdata = 16'h0000;
        #1 if (stall) stall_cnt++;
        chk("lw_stall_cycles", stall_cnt, 4);
        chk("lw_done_req", u_if.req, 0);
        chk("lw_wb_data", wb_data, 16'hBEEF);
        chk("lw_wb_en", wb_en, 1);
        chk("lw_wb_addr", wb_addr, 5);
        chk("lw_inst_out", inst_out, 16'h8A45);
        cyc(); set_in(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000);
        #1;
        chk("lw_bubble_en", wb_en, 0);
        chk("lw_bubble_data", wb_data, 0);
        chk("lw_idle_stall", stall, 0);

        // 3: SW, ack in first BUSY cycle
        cyc(); set_in(16'h9123, 16'h0010, 1'b1, 3'd2, 16'h5A5A);
        #1 chk("sw_idle_stall", stall, 1);
        cyc(); u_if.ack = 1'b1; u_if.rdata = 16'hFFFF;
        #1;
        chk("sw_req", u_if.req, 1);
        chk("sw_we", u_if.we, 1);
        chk("sw_wdata", u_if.wdata, 16'h5A5A);
        chk("sw_addr", u_if.addr, 16'h0010);
        chk("sw_busy_stall", stall, 1);
        cyc(); u_if.ack = 1'b0;
        #1;
        chk("sw_done_stall", stall, 0);
        chk("sw_wb_en", wb_en, 0);
        chk("sw_wb_data", wb_data, 16'h0010);
        chk("sw_inst_out", inst_out, 16'h9123);
        chk("sw_done_we", u_if.we, 0);
        cyc(); set_in(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000);

        // 4: LW timeout, then a late ack
        cyc(); set_in(16'h8111, 16'h0077, 1'b1, 3'd1, 16'h0000);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(); #1;
            if (u_if.req) busy_cnt++;
            else break;
            chk("to_no_err", err, 0);
        end
        chk("to_req_cycles", busy_cnt, 15);
        chk("to_err", err, 1);
        chk("to_wb_en", wb_en, 0);
        chk("to_stall", stall, 0);
        cyc(); set_in(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000);
        u_if.ack = 1'b1; u_if.rdata = 16'h1357;
        #1;
        chk("to_err_clear", err, 0);
        chk("late_ack_req", u_if.req, 0);
        chk("late_ack_wb_en", wb_en, 0);
        cyc(); u_if.ack = 1'b0;
        #1;
        chk("late_ack_wb_data", wb_data, 0);
        chk("late_ack_req2", u_if.req, 0);

        // 4b: ack arriving in the timeout cycle completes normally
        cyc(); set_in(16'h8555, 16'h0099, 1'b1, 3'd6, 16'h0000);
        for (int i = 0; i < 15; i++) begin
            cyc();
            u_if.ack = (i == 14);
            u_if.rdata = 16'hABCD;
        end
        cyc(); u_if.ack = 1'b0;
        #1;
        chk("to_ack_err", err, 0);
        chk("to_ack_wb_data", wb_data, 16'hABCD);
        chk("to_ack_wb_en", wb_en, 1);
        cyc(); set_in(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000);

        // 5: reset in the second BUSY cycle
        cyc(); set_in(16'h8222, 16'h0033, 1'b1, 3'd2, 16'h0000);
        cyc();
        cyc(); rst = 1'b1;
        #1 chk("rst_busy_req", u_if.req, 1);
        cyc(); rst = 1'b0; set_in(16'h2345, 16'h0101, 1'b1, 3'd4, 16'h0000);
        #1;
        chk("rst_abort_req", u_if.req, 0);
        chk("rst_abort_stall", stall, 0);
        chk("rst_abort_addr", u_if.addr, 0);
        chk("rst_abort_inst", inst_out, 0);
        cyc(); set_in(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000);
        #1 chk("rst_idle_pass", wb_data, 16'h0101);

        // 6: back-to-back LW, ALU, SW
        cyc(); set_in(16'h8333, 16'h0050, 1'b1, 3'd6, 16'h0000);
        req_cycles = 0;
        req_issues = 0;
        cyc(); u_if.ack = 1'b1; u_if.rdata = 16'hCAFE;
        cyc(); u_if.ack = 1'b0;
        #1;
        chk("b2b_lw_data", wb_data, 16'hCAFE);
        chk("b2b_lw_en", wb_en, 1);
        cyc(); set_in(16'h3456, 16'h0202, 1'b1, 3'd7, 16'h0000);
        #1;
        chk("b2b_bubble_en", wb_en, 0);
        chk("b2b_alu_stall", stall, 0);
        cyc(); set_in(16'h9444, 16'h0060, 1'b0, 3'd0, 16'h1111);
        #1;
        chk("b2b_alu_data", wb_data, 16'h0202);
        chk("b2b_alu_addr", wb_addr, 7);
        chk("b2b_sw_stall", stall, 1);
        cyc(); u_if.ack = 1'b1;
        #1;
        chk("b2b_sw_we", u_if.we, 1);
        chk("b2b_sw_addr", u_if.addr, 16'h0060);
        cyc(); u_if.ack = 1'b0;
        #1 chk("b2b_sw_inst", inst_out, 16'h9444);
        cyc(); set_in(16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000);
        cyc(); cyc();
        #1;
        chk("b2b_issues", req_issues, 2);
        chk("b2b_req_cycles", req_cycles, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
